// File: rtl/lens_placement_ctrl.sv
// Lens placement controller: turns button pulses into edits of a preview lens,
// commits it into a small lens table, supports undo/clear, and publishes the
// whole configuration atomically at frame start.
module lens_placement_ctrl #(
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240,
   parameter int MAX_LENS   = 8,
   parameter int POS_STEP   = 4,
   parameter int R_STEP     = 4,
   parameter int K_STEP     = 8,
   parameter int R_MIN      = 8,
   parameter int R_MAX      = 120,
   parameter int R_DEFAULT  = 40,
   parameter int K_DEFAULT  = 128
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_start,
   input  logic       sw0_edit_mode,
   input  logic [1:0] sel,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_commit,
   input  logic       btn_undo,
   input  logic       btn_clear,
   output logic [8:0] current_center_x,
   output logic [7:0] current_center_y,
   output logic [7:0] current_R,
   output logic [7:0] current_K,
   output logic       preview_enable,
   output logic [2:0] lens_count,
   output logic [8:0] lens_center_x [0:MAX_LENS-1],
   output logic [7:0] lens_center_y [0:MAX_LENS-1],
   output logic [7:0] lens_R        [0:MAX_LENS-1],
   output logic [7:0] lens_K        [0:MAX_LENS-1],
   output logic       busy,
   output logic       full
);

   localparam logic [8:0] X_RST  = 9'(IMG_WIDTH / 2);
   localparam logic [7:0] Y_RST  = 8'(IMG_HEIGHT / 2);
   localparam logic [7:0] R_RST  = 8'(R_DEFAULT);
   localparam logic [7:0] K_RST  = 8'(K_DEFAULT);
   localparam logic [9:0] X_MAX  = 10'(IMG_WIDTH - 1);
   localparam logic [9:0] Y_MAX  = 10'(IMG_HEIGHT - 1);
   localparam logic [9:0] RMIN10 = 10'(R_MIN);
   localparam logic [9:0] RMAX10 = 10'(R_MAX);
   localparam logic [9:0] KMAX10 = 10'd255;
   localparam logic [9:0] PS     = 10'(POS_STEP);
   localparam logic [9:0] RS     = 10'(R_STEP);
   localparam logic [9:0] KS     = 10'(K_STEP);
   localparam logic [2:0] CNT_FULL = 3'(MAX_LENS - 1);
   localparam logic [2:0] CLR_LAST = 3'(MAX_LENS - 1);

   typedef enum logic [1:0] {S_EDIT, S_COMMIT, S_CLEAR} state_t;

   state_t     state_q, state_d;
   logic [8:0] cx_q, cx_d;
   logic [7:0] cy_q, cy_d, r_q, r_d, k_q, k_d;
   logic [2:0] cnt_q, cnt_d, clr_q, clr_d;
   logic       pend_q, pend_d, edit_q;

   // working lens table
   logic [8:0] wtx_q [0:MAX_LENS-1];
   logic [7:0] wty_q [0:MAX_LENS-1];
   logic [7:0] wtr_q [0:MAX_LENS-1];
   logic [7:0] wtk_q [0:MAX_LENS-1];

   logic       tbl_we;
   logic [2:0] tbl_idx;
   logic [8:0] tbl_x;
   logic [7:0] tbl_y, tbl_r, tbl_k;
   logic [9:0] x10, y10, r10, k10, xs, ys, rs, ks;
   logic       publish, chg;

   assign busy    = (state_q != S_EDIT);
   assign full    = (cnt_q == CNT_FULL);
   assign publish = frame_start && (state_q == S_EDIT) && pend_q;

   // Next-state, working-lens edits and table write request
   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      r_d     = r_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      clr_d   = clr_q;
      tbl_we  = 1'b0;
      tbl_idx = cnt_q;
      tbl_x   = cx_q;
      tbl_y   = cy_q;
      tbl_r   = r_q;
      tbl_k   = k_q;
      x10     = {1'b0, cx_q};
      y10     = {2'b0, cy_q};
      r10     = {2'b0, r_q};
      k10     = {2'b0, k_q};
      xs      = x10;
      ys      = y10;
      rs      = r10;
      ks      = k10;
      unique case (state_q)
         S_EDIT: begin
            if (sw0_edit_mode) begin
               if (btn_clear) begin
                  state_d = S_CLEAR;
                  clr_d   = 3'd0;
               end else if (btn_undo) begin
                  if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
               end else if (btn_commit) begin
                  if (!full) state_d = S_COMMIT;
               end else begin
                  // Saturating moves: test against the bound before stepping
                  // so nothing ever wraps.
                  if (btn_right && !btn_left)
                     xs = (x10 + PS > X_MAX) ? X_MAX : x10 + PS;
                  else if (btn_left && !btn_right)
                     xs = (x10 < PS) ? 10'd0 : x10 - PS;
                  if (btn_up ^ btn_down) begin
                     unique case (sel)
                        2'd0: ys = btn_up ? ((y10 < PS) ? 10'd0 : y10 - PS)
                                          : ((y10 + PS > Y_MAX) ? Y_MAX : y10 + PS);
                        2'd1: rs = btn_up ? ((r10 + RS > RMAX10) ? RMAX10 : r10 + RS)
                                          : ((r10 < RMIN10 + RS) ? RMIN10 : r10 - RS);
                        2'd2: ks = btn_up ? ((k10 + KS > KMAX10) ? KMAX10 : k10 + KS)
                                          : ((k10 < KS) ? 10'd0 : k10 - KS);
                        default: ;
                     endcase
                  end
                  cx_d = xs[8:0];
                  cy_d = ys[7:0];
                  r_d  = rs[7:0];
                  k_d  = ks[7:0];
               end
            end
         end
         S_COMMIT: begin
            tbl_we  = 1'b1;
            cnt_d   = cnt_q + 3'd1;
            r_d     = R_RST;
            k_d     = K_RST;
            state_d = S_EDIT;
         end
         S_CLEAR: begin
            tbl_we  = 1'b1;
            tbl_idx = clr_q;
            tbl_x   = 9'd0;
            tbl_y   = 8'd0;
            tbl_r   = 8'd0;
            tbl_k   = 8'd0;
            clr_d   = clr_q + 3'd1;
            if (clr_q == CLR_LAST) begin
               cnt_d   = 3'd0;
               state_d = S_EDIT;
            end
         end
         default: state_d = S_EDIT;
      endcase
      // Any working change (or an edit-mode toggle) arms the next publish.
      chg = (cx_d != cx_q) || (cy_d != cy_q) || (r_d != r_q) || (k_d != k_q) ||
            (cnt_d != cnt_q) || tbl_we || (sw0_edit_mode != edit_q);
      pend_d = (pend_q && !publish) || chg;
   end

   // Working state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_EDIT;
         cx_q    <= X_RST;
         cy_q    <= Y_RST;
         r_q     <= R_RST;
         k_q     <= K_RST;
         cnt_q   <= 3'd0;
         clr_q   <= 3'd0;
         pend_q  <= 1'b0;
         edit_q  <= 1'b0;
         for (int i = 0; i < MAX_LENS; i++) begin
            wtx_q[i] <= 9'd0;
            wty_q[i] <= 8'd0;
            wtr_q[i] <= 8'd0;
            wtk_q[i] <= 8'd0;
         end
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         r_q     <= r_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         clr_q   <= clr_d;
         pend_q  <= pend_d;
         edit_q  <= sw0_edit_mode;
         if (tbl_we) begin
            wtx_q[tbl_idx] <= tbl_x;
            wty_q[tbl_idx] <= tbl_y;
            wtr_q[tbl_idx] <= tbl_r;
            wtk_q[tbl_idx] <= tbl_k;
         end
      end
   end

   // Published copy: single atomic update on a qualifying frame_start
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         current_center_x <= X_RST;
         current_center_y <= Y_RST;
         current_R        <= R_RST;
         current_K        <= K_RST;
         preview_enable   <= 1'b0;
         lens_count       <= 3'd0;
         for (int i = 0; i < MAX_LENS; i++) begin
            lens_center_x[i] <= 9'd0;
            lens_center_y[i] <= 8'd0;
            lens_R[i]        <= 8'd0;
            lens_K[i]        <= 8'd0;
         end
      end else if (publish) begin
         current_center_x <= cx_q;
         current_center_y <= cy_q;
         current_R        <= r_q;
         current_K        <= k_q;
         preview_enable   <= sw0_edit_mode;
         lens_count       <= cnt_q;
         for (int i = 0; i < MAX_LENS; i++) begin
            lens_center_x[i] <= wtx_q[i];
            lens_center_y[i] <= wty_q[i];
            lens_R[i]        <= wtr_q[i];
            lens_K[i]        <= wtk_q[i];
         end
      end
   end

endmodule

// File: tb/tb_lens_placement_ctrl.sv
// Self-checking bench for lens_placement_ctrl: an integer-level model of the
// working/published configuration checked every cycle, plus literal anchors.
module tb_lens_placement_ctrl;

   localparam int ML = 8;

   logic       clk = 1'b0, reset = 1'b1, frame_start = 1'b0, sw0_edit_mode = 1'b0;
   logic [1:0] sel = 2'd0;
   logic       btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
   logic       btn_commit = 0, btn_undo = 0, btn_clear = 0;
   logic [8:0] current_center_x;
   logic [7:0] current_center_y, current_R, current_K;
   logic       preview_enable, busy, full;
   logic [2:0] lens_count;
   logic [8:0] lens_center_x [0:ML-1];
   logic [7:0] lens_center_y [0:ML-1];
   logic [7:0] lens_R [0:ML-1];
   logic [7:0] lens_K [0:ML-1];

   lens_placement_ctrl dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .sw0_edit_mode(sw0_edit_mode),
      .sel(sel), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
      .btn_right(btn_right), .btn_commit(btn_commit), .btn_undo(btn_undo),
      .btn_clear(btn_clear), .current_center_x(current_center_x),
      .current_center_y(current_center_y), .current_R(current_R), .current_K(current_K),
      .preview_enable(preview_enable), .lens_count(lens_count),
      .lens_center_x(lens_center_x), .lens_center_y(lens_center_y),
      .lens_R(lens_R), .lens_K(lens_K), .busy(busy), .full(full));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   // model: working (m_*) and published (p_*) configuration
   int m_x, m_y, m_r, m_k, m_cnt, m_busy, m_pend, m_sw;
   bit m_clr;
   int m_tx[ML], m_ty[ML], m_tr[ML], m_tk[ML];
   int p_x, p_y, p_r, p_k, p_cnt, p_pe;
   int p_tx[ML], p_ty[ML], p_tr[ML], p_tk[ML];

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_x = 160; m_y = 120; m_r = 40; m_k = 128; m_cnt = 0; m_busy = 0;
      m_pend = 0; m_sw = 0; m_clr = 0;
      p_x = 160; p_y = 120; p_r = 40; p_k = 128; p_cnt = 0; p_pe = 0;
      for (int i = 0; i < ML; i++) begin
         m_tx[i] = 0; m_ty[i] = 0; m_tr[i] = 0; m_tk[i] = 0;
         p_tx[i] = 0; p_ty[i] = 0; p_tr[i] = 0; p_tk[i] = 0;
      end
   endtask

   // one clock edge of the model, using the inputs the DUT sampled
   task automatic model_step();
      int ox, oy, orr, ok, np;
      if (frame_start && m_busy == 0 && m_pend != 0) begin
         p_x = m_x; p_y = m_y; p_r = m_r; p_k = m_k; p_cnt = m_cnt;
         p_pe = int'(sw0_edit_mode);
         for (int i = 0; i < ML; i++) begin
            p_tx[i] = m_tx[i]; p_ty[i] = m_ty[i]; p_tr[i] = m_tr[i]; p_tk[i] = m_tk[i];
         end
         np = 0;
      end else np = m_pend;
      if (int'(sw0_edit_mode) != m_sw) np = 1;
      m_sw = int'(sw0_edit_mode);
      if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) begin
            if (m_clr) begin
               for (int i = 0; i < ML; i++) begin
                  m_tx[i] = 0; m_ty[i] = 0; m_tr[i] = 0; m_tk[i] = 0;
               end
               m_cnt = 0;
            end else begin
               m_tx[m_cnt] = m_x; m_ty[m_cnt] = m_y; m_tr[m_cnt] = m_r; m_tk[m_cnt] = m_k;
               m_cnt++; m_r = 40; m_k = 128;
            end
            np = 1;
         end
      end else if (sw0_edit_mode) begin
         if (btn_clear) begin
            m_busy = ML; m_clr = 1; np = 1;
         end else if (btn_undo) begin
            if (m_cnt > 0) begin m_cnt--; np = 1; end
         end else if (btn_commit) begin
            if (m_cnt < ML - 1) begin m_busy = 1; m_clr = 0; np = 1; end
         end else begin
            ox = m_x; oy = m_y; orr = m_r; ok = m_k;
            if (btn_right && !btn_left) m_x = clampi(m_x + 4, 0, 319);
            if (btn_left && !btn_right) m_x = clampi(m_x - 4, 0, 319);
            if (btn_up != btn_down) begin
               if (sel == 0) m_y = clampi(btn_up ? m_y - 4 : m_y + 4, 0, 239);
               if (sel == 1) m_r = clampi(btn_up ? m_r + 4 : m_r - 4, 8, 120);
               if (sel == 2) m_k = clampi(btn_up ? m_k + 8 : m_k - 8, 0, 255);
            end
            if (ox != m_x || oy != m_y || orr != m_r || ok != m_k) np = 1;
         end
      end
      m_pend = np;
   endtask

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      chk("cx", current_center_x, p_x);
      chk("cy", current_center_y, p_y);
      chk("R", current_R, p_r);
      chk("K", current_K, p_k);
      chk("pe", preview_enable, p_pe);
      chk("cnt", lens_count, p_cnt);
      chk("busy", busy, (m_busy > 0) ? 1 : 0);
      chk("full", full, (m_cnt == ML - 1) ? 1 : 0);
      for (int i = 0; i < ML; i++) begin
         chk($sformatf("lx[%0d]", i), lens_center_x[i], p_tx[i]);
         chk($sformatf("ly[%0d]", i), lens_center_y[i], p_ty[i]);
         chk($sformatf("lr[%0d]", i), lens_R[i], p_tr[i]);
         chk($sformatf("lk[%0d]", i), lens_K[i], p_tk[i]);
      end
   end

   task automatic tick();
      @(posedge clk);
      if (reset) model_reset(); else model_step();
      #1;
   endtask

   // mask bits: 0 up,1 down,2 left,3 right,4 commit,5 undo,6 clear,7 frame_start
   task automatic pulse(input int m);
      btn_up = m[0]; btn_down = m[1]; btn_left = m[2]; btn_right = m[3];
      btn_commit = m[4]; btn_undo = m[5]; btn_clear = m[6]; frame_start = m[7];
      tick();
      {btn_up, btn_down, btn_left, btn_right, btn_commit, btn_undo, btn_clear, frame_start} = '0;
   endtask

   localparam int UP = 1, DN = 2, LF = 4, RT = 8, CM = 16, UD = 32, CL = 64, FS = 128;

   initial begin
      int nb;
      model_reset();
      repeat (2) tick();
      reset = 1'b0;
      tick();
      pulse(FS);
      chk("lit_rst_x", current_center_x, 160);
      chk("lit_rst_R", current_R, 40);
      chk("lit_rst_K", current_K, 128);
      chk("lit_rst_pe", preview_enable, 0);

      sw0_edit_mode = 1'b1;
      repeat (3) pulse(RT);
      sel = 2'd1;
      repeat (2) pulse(UP);
      pulse(LF | RT);
      pulse(UP | DN);
      chk("lit_nopub_x", current_center_x, 160);
      pulse(FS);
      chk("lit_pub_x", current_center_x, 172);
      chk("lit_pub_R", current_R, 48);
      chk("lit_pub_pe", preview_enable, 1);

      repeat (37) pulse(RT);
      sel = 2'd0;
      repeat (31) pulse(UP);
      sel = 2'd2;
      repeat (16) pulse(UP);
      sel = 2'd3;
      pulse(UP);
      pulse(FS);
      chk("lit_sat_x", current_center_x, 319);
      chk("lit_sat_y", current_center_y, 0);
      chk("lit_sat_K", current_K, 255);

      for (int i = 0; i < 8; i++) begin
         pulse(LF);
         pulse(CM);
         tick();
         pulse(FS);
      end
      chk("lit_full_cnt", lens_count, 7);
      chk("lit_full", full, 1);
      chk("lit_8th_busy", busy, 0);
      chk("lit_slot6_x", lens_center_x[6], 291);
      chk("lit_slot0_R", lens_R[0], 48);
      chk("lit_slot0_K", lens_K[0], 255);
      chk("lit_cur_R", current_R, 40);

      repeat (4) pulse(UD);
      pulse(FS);
      chk("lit_undo_cnt", lens_count, 3);
      pulse(CL | CM);
      nb = 0;
      for (int c = 0; c < 20 && busy; c++) begin
         nb++;
         if (c == 2) pulse(FS); else tick();
      end
      chk("lit_clear_busy_cycles", nb, 8);
      chk("lit_clear_nopub", lens_count, 3);
      pulse(FS);
      chk("lit_clear_cnt", lens_count, 0);
      chk("lit_clear_slot0", lens_center_x[0], 0);

      pulse(CM); tick();
      pulse(CM); tick();
      pulse(FS);
      pulse(CL);
      repeat (3) tick();
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("lit_arst_busy", busy, 0);
      chk("lit_arst_cnt", lens_count, 0);
      chk("lit_arst_x", current_center_x, 160);
      chk("lit_arst_pe", preview_enable, 0);
      tick();
      reset = 1'b0;
      tick();
      pulse(UD);
      pulse(FS);
      chk("lit_undo0_cnt", lens_count, 0);
      chk("lit_undo0_pe", preview_enable, 1);
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
